// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32 datapath with a memory-wait timeout trap
//   Clk, Rst_N   : clock, asynchronous active-low reset
//   Instruction  : instruction-register contents
//   Mem_Ready    : memory completes the current request this cycle
//   Branch_Taken : branch comparison result, sampled in EXEC
//   Mem_Req, Mem_We, IR_Write, PC_Write, PC_Sel, ALU_Src_A, ALU_Src_B, Reg_Write, Trap : datapath strobes
//   Imm_Sel      : immediate format (I/S/B/J), Wb_Sel : writeback source (ALU/mem/PC+4/imm)
//   State        : current FSM state for debug
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic [31:0] Instruction,
  input  logic        Mem_Ready,
  input  logic        Branch_Taken,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic        IR_Write,
  output logic        PC_Write,
  output logic        PC_Sel,
  output logic        ALU_Src_A,
  output logic        ALU_Src_B,
  output logic        Reg_Write,
  output logic        Trap,
  output logic [1:0]  Imm_Sel,
  output logic [1:0]  Wb_Sel,
  output logic [2:0]  State
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] op_q, op;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic req, waiting, timeout, in_instr;
  logic [1:0] imm, wb;
  logic unused_bits;
  assign unused_bits = ^Instruction[31:12];
  // Opcode is taken live in DECODE and frozen for the rest of the instruction
  assign op       = (state_q == DECODE) ? Instruction[6:0] : op_q;
  assign is_r     = op == 7'h33;
  assign is_i     = op == 7'h13;
  assign is_ld    = op == 7'h03;
  assign is_st    = op == 7'h23;
  assign is_br    = op == 7'h63;
  assign is_jal   = op == 7'h6F;
  assign is_jalr  = op == 7'h67;
  assign is_lui   = op == 7'h37;
  assign is_auipc = op == 7'h17;
  assign legal    = |{is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc};
  assign imm      = is_st ? 2'd1 : is_br ? 2'd2 : (is_jal | is_lui | is_auipc) ? 2'd3 : 2'd0;
  assign wb       = is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
  assign req      = (state_q == FETCH) || (state_q == MEM);
  // Counter is zero outside a stalled request, so entry to FETCH/MEM and any Mem_Ready clear it
  assign waiting  = req & ~Mem_Ready;
  assign timeout  = waiting && (cnt_q == CNT_LAST);
  assign cnt_d    = waiting ? cnt_q + CW'(1) : '0;
  assign in_instr = (state_q == DECODE) || (state_q == EXEC) || (state_q == MEM) || (state_q == WB);
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = Mem_Ready ? DECODE : timeout ? TRAP : FETCH;
      DECODE:  state_d = legal ? EXEC : TRAP;
      EXEC:    state_d = is_br ? FETCH : (is_ld | is_st) ? MEM : WB;
      MEM:     state_d = !Mem_Ready ? (timeout ? TRAP : MEM) : is_st ? FETCH : WB;
      WB:      state_d = FETCH;
      default: state_d = TRAP;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op;
    end
  end
  // Every output is gated by Rst_N so reset silences the datapath combinationally
  assign Mem_Req   = Rst_N & req;
  assign Mem_We    = Rst_N & (state_q == MEM) & is_st;
  assign IR_Write  = Rst_N & (state_q == FETCH) & Mem_Ready;
  assign PC_Write  = Rst_N & (((state_q == EXEC) & is_br) | ((state_q == MEM) & is_st & Mem_Ready) | (state_q == WB));
  assign PC_Sel    = Rst_N & (((state_q == EXEC) & is_br & Branch_Taken) | ((state_q == WB) & (is_jal | is_jalr)));
  assign ALU_Src_A = Rst_N & (state_q == EXEC) & (is_auipc | is_jal);
  assign ALU_Src_B = Rst_N & (state_q == EXEC) & ~(is_r | is_br);
  assign Reg_Write = Rst_N & (state_q == WB) & (|Instruction[11:7]);
  assign Trap      = Rst_N & (state_q == TRAP);
  assign Imm_Sel   = (Rst_N & in_instr) ? imm : 2'd0;
  assign Wb_Sel    = (Rst_N & (state_q == WB)) ? wb : 2'd0;
  assign State     = Rst_N ? state_q : FETCH;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of multicycle_ctrl against a behavioural model
module tb_multicycle_ctrl;
  localparam int TO = 4;
  logic        Clk = 1'b0;
  logic        Rst_N;
  logic [31:0] Instruction;
  logic        Mem_Ready, Branch_Taken;
  logic        Mem_Req, Mem_We, IR_Write, PC_Write, PC_Sel, ALU_Src_A, ALU_Src_B, Reg_Write, Trap;
  logic [1:0]  Imm_Sel, Wb_Sel;
  logic [2:0]  State;
  logic [15:0] outs;
  int vectors = 0;
  int miscompares = 0;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Instruction(Instruction), .Mem_Ready(Mem_Ready),
    .Branch_Taken(Branch_Taken), .Mem_Req(Mem_Req), .Mem_We(Mem_We), .IR_Write(IR_Write),
    .PC_Write(PC_Write), .PC_Sel(PC_Sel), .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B),
    .Reg_Write(Reg_Write), .Trap(Trap), .Imm_Sel(Imm_Sel), .Wb_Sel(Wb_Sel), .State(State)
  );

  always #5 Clk = ~Clk;

  // Strobe order: Mem_Req Mem_We IR_Write PC_Write PC_Sel ALU_Src_A ALU_Src_B Reg_Write Trap
  assign outs = {Mem_Req, Mem_We, IR_Write, PC_Write, PC_Sel, ALU_Src_A, ALU_Src_B, Reg_Write, Trap,
                 Imm_Sel, Wb_Sel, State};

  typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD} kind_e;

  function automatic kind_e kind(input logic [6:0] op);
    case (op)
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h03:   return K_LD;
      7'h23:   return K_ST;
      7'h63:   return K_BR;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      7'h37:   return K_LUI;
      7'h17:   return K_AUIPC;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input kind_e k);
    return (k == K_ST) ? 2'd1 : (k == K_BR) ? 2'd2 : (k == K_JAL || k == K_LUI || k == K_AUIPC) ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [1:0] wb_of(input kind_e k);
    return (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : (k == K_LUI) ? 2'd3 : 2'd0;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: outputs %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: phase of the current instruction, cycles spent waiting on memory,
  // the latched opcode, and whether the IR was just loaded
  logic [2:0] m_st = 3'd0;
  int         m_wait = 0;
  logic [6:0] m_op = 7'h00;
  logic       ir_load = 1'b0;
  kind_e      mk_k;
  logic [15:0] e;
  kind_e       ck;

  always @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      m_st = 3'd0;
      m_wait = 0;
      ir_load = 1'b0;
    end else begin
      mk_k = kind(m_op);
      ir_load = (m_st == 3'd0) && Mem_Ready;
      m_wait = ((m_st == 3'd0 || m_st == 3'd3) && !Mem_Ready) ? m_wait + 1 : 0;
      case (m_st)
        3'd0: m_st = Mem_Ready ? 3'd1 : (m_wait == TO) ? 3'd5 : 3'd0;
        3'd1: begin
          m_op = Instruction[6:0];
          m_st = (kind(m_op) == K_BAD) ? 3'd5 : 3'd2;
        end
        3'd2: m_st = (mk_k == K_BR) ? 3'd0 : (mk_k == K_LD || mk_k == K_ST) ? 3'd3 : 3'd4;
        3'd3: m_st = !Mem_Ready ? ((m_wait == TO) ? 3'd5 : 3'd3) : (mk_k == K_ST) ? 3'd0 : 3'd4;
        3'd4: m_st = 3'd0;
        default: m_st = 3'd5;
      endcase
    end
  end

  always @(negedge Clk) begin
    ck = kind((m_st == 3'd1) ? Instruction[6:0] : m_op);
    if (!Rst_N) e = '0;
    else case (m_st)
      3'd0: e = {1'b1, 1'b0, Mem_Ready, 6'b0, 2'd0, 2'd0, 3'd0};
      3'd1: e = {9'b0, imm_of(ck), 2'd0, 3'd1};
      3'd2: e = {3'b000, ck == K_BR, (ck == K_BR) && Branch_Taken, ck == K_AUIPC || ck == K_JAL,
                 !(ck == K_R || ck == K_BR), 2'b00, imm_of(ck), 2'd0, 3'd2};
      3'd3: e = {1'b1, ck == K_ST, 1'b0, (ck == K_ST) && Mem_Ready, 5'b0, imm_of(ck), 2'd0, 3'd3};
      3'd4: e = {3'b000, 1'b1, ck == K_JAL || ck == K_JALR, 2'b00, |Instruction[11:7], 1'b0,
                 imm_of(ck), wb_of(ck), 3'd4};
      default: e = {8'b0, 1'b1, 2'd0, 2'd0, 3'd5};
    endcase
    chk("model", outs, e);
  end

  task automatic tick(input logic rdy, input logic bt, input string name, input logic [15:0] exp);
    Mem_Ready = rdy;
    Branch_Taken = bt;
    @(negedge Clk);
    chk(name, outs, exp);
    @(posedge Clk);
    #1;
  endtask

  task automatic rst_pulse();
    Rst_N = 1'b0;
    @(posedge Clk);
    #1;
    Rst_N = 1'b1;
  endtask

  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    x[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
    if ($urandom_range(0, 4) == 0) x[11:7] = 5'd0;
    return x;
  endfunction

  initial begin
    Rst_N = 1'b0;
    Instruction = 32'h0;
    Mem_Ready = 1'b0;
    Branch_Taken = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outs", outs, 16'h0000);
    Rst_N = 1'b1;
    Instruction = 32'h00500093;
    tick(1'b1, 1'b0, "addi_fetch",  {9'b101000000, 2'd0, 2'd0, 3'd0});
    tick(1'b1, 1'b0, "addi_decode", {9'b000000000, 2'd0, 2'd0, 3'd1});
    tick(1'b1, 1'b0, "addi_exec",   {9'b000000100, 2'd0, 2'd0, 3'd2});
    tick(1'b1, 1'b0, "addi_wb",     {9'b000100010, 2'd0, 2'd0, 3'd4});
    Instruction = 32'h00112223;
    tick(1'b1, 1'b0, "sw_fetch",    {9'b101000000, 2'd0, 2'd0, 3'd0});
    tick(1'b1, 1'b0, "sw_decode",   {9'b000000000, 2'd1, 2'd0, 3'd1});
    tick(1'b1, 1'b0, "sw_exec",     {9'b000000100, 2'd1, 2'd0, 3'd2});
    tick(1'b0, 1'b0, "sw_mem_wait", {9'b110000000, 2'd1, 2'd0, 3'd3});
    tick(1'b1, 1'b0, "sw_mem_done", {9'b110100000, 2'd1, 2'd0, 3'd3});
    Instruction = 32'h00000463;
    tick(1'b1, 1'b1, "beq_fetch",   {9'b101000000, 2'd0, 2'd0, 3'd0});
    tick(1'b1, 1'b1, "beq_decode",  {9'b000000000, 2'd2, 2'd0, 3'd1});
    tick(1'b1, 1'b1, "beq_exec",    {9'b000110000, 2'd2, 2'd0, 3'd2});
    Instruction = 32'h00001037;
    tick(1'b1, 1'b0, "lui_fetch",   {9'b101000000, 2'd0, 2'd0, 3'd0});
    tick(1'b1, 1'b0, "lui_decode",  {9'b000000000, 2'd3, 2'd0, 3'd1});
    tick(1'b1, 1'b0, "lui_exec",    {9'b000000100, 2'd3, 2'd0, 3'd2});
    tick(1'b1, 1'b0, "lui_wb_rd0",  {9'b000100000, 2'd3, 2'd3, 3'd4});
    Instruction = 32'h008000EF;
    tick(1'b1, 1'b0, "jal_fetch",   {9'b101000000, 2'd0, 2'd0, 3'd0});
    tick(1'b1, 1'b0, "jal_decode",  {9'b000000000, 2'd3, 2'd0, 3'd1});
    tick(1'b1, 1'b0, "jal_exec",    {9'b000001100, 2'd3, 2'd0, 3'd2});
    tick(1'b1, 1'b0, "jal_wb",      {9'b000110010, 2'd3, 2'd2, 3'd4});
    Instruction = 32'h00002083;
    tick(1'b1, 1'b0, "lw_fetch",    {9'b101000000, 2'd0, 2'd0, 3'd0});
    tick(1'b1, 1'b0, "lw_decode",   {9'b000000000, 2'd0, 2'd0, 3'd1});
    tick(1'b1, 1'b0, "lw_exec",     {9'b000000100, 2'd0, 2'd0, 3'd2});
    Mem_Ready = 1'b0;
    @(negedge Clk);
    chk("lw_mem", outs, {9'b100000000, 2'd0, 2'd0, 3'd3});
    @(posedge Clk);
    #3;
    Rst_N = 1'b0;
    #1;
    chk("rst_mid_mem", outs, 16'h0000);
    @(posedge Clk);
    #1;
    Rst_N = 1'b1;
    tick(1'b0, 1'b0, "post_rst_fetch", {9'b100000000, 2'd0, 2'd0, 3'd0});
    Instruction = 32'h0000007F;
    tick(1'b1, 1'b0, "bad_fetch",   {9'b101000000, 2'd0, 2'd0, 3'd0});
    tick(1'b1, 1'b0, "bad_decode",  {9'b000000000, 2'd0, 2'd0, 3'd1});
    repeat (20) tick(1'($urandom), 1'($urandom), "trap_hold", {9'b000000001, 2'd0, 2'd0, 3'd5});
    rst_pulse();
    repeat (TO) tick(1'b0, 1'b0, "to_wait", {9'b100000000, 2'd0, 2'd0, 3'd0});
    tick(1'b0, 1'b0, "to_trap",     {9'b000000001, 2'd0, 2'd0, 3'd5});
    rst_pulse();
    repeat (TO - 1) tick(1'b0, 1'b0, "to_wait2", {9'b100000000, 2'd0, 2'd0, 3'd0});
    tick(1'b1, 1'b0, "to_rescue",   {9'b101000000, 2'd0, 2'd0, 3'd0});
    tick(1'b0, 1'b0, "to_decode",   {9'b000000000, 2'd0, 2'd0, 3'd1});
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clk);
      #1;
      Rst_N = 1'b1;
      if (ir_load) Instruction = rand_instr();
      Mem_Ready = $urandom_range(0, 9) < 7;
      Branch_Taken = 1'($urandom);
      if ($urandom_range(0, 59) == 0 || (m_st == 3'd5 && $urandom_range(0, 3) == 0)) begin
        #2;
        Rst_N = 1'b0;
      end
    end
    @(posedge Clk);
    #1;
    Rst_N = 1'b1;
    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
